// File: rtl/dmem_pipe.sv
// Byte-addressable data memory with a valid/ready request port and a fixed-latency
// response pipeline; supports 1/2/4/8-byte little-endian accesses with bounds checking.
module dmem_pipe #(
  parameter int ADDR_W         = 10,
  parameter int DATA_BYTES     = 8,
  parameter int LATENCY        = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [63:0]             req_addr,
  input  logic [1:0]              req_size,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int WORDS  = DEPTH / DATA_BYTES;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF_W  = $clog2(DATA_BYTES);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   init_idx;
  logic [ADDR_W-1:0]  init_base;
  logic [7:0]         mem [DEPTH];

  logic               accept;
  logic               err;
  logic [3:0]         nbytes;
  logic [64:0]        end_addr;
  logic [ADDR_W-1:0]  base;
  logic [DATA_W-1:0]  rd_word;

  logic               pipe_valid [LATENCY];
  logic [DATA_W-1:0]  pipe_rdata [LATENCY];
  logic               pipe_err   [LATENCY];

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in RUN and never while reset is asserted.
  assign req_ready = (state == RUN) && !reset;
  assign busy      = reset ? (CLEAR_ON_RESET != 0) : (state == INIT);
  assign accept    = req_valid && req_ready;

  // End address is formed at 65 bits so addresses near 2**64 cannot wrap into range.
  assign nbytes    = 4'd1 << req_size;
  assign end_addr  = {1'b0, req_addr} + 65'(nbytes);
  assign err       = (end_addr > 65'(DEPTH)) || (nbytes > 4'(DATA_BYTES));
  assign base      = req_addr[ADDR_W-1:0];
  assign init_base = ADDR_W'(init_idx) << OFF_W;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (!err && (i < int'(nbytes))) rd_word[8*i +: 8] = mem[base + ADDR_W'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
      init_idx <= '0;
    end else if (state == INIT) begin
      init_idx <= init_idx + 1'b1;
      if (init_idx == IDX_W'(WORDS - 1)) state <= RUN;
    end
  end

  // The array itself has no reset; clearing is done only by the INIT sweep.
  always_ff @(posedge clk) begin
    if (!reset && (state == INIT)) begin
      for (int i = 0; i < DATA_BYTES; i++) mem[init_base + ADDR_W'(i)] <= 8'h00;
    end else if (accept && req_wr && !err) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (i < int'(nbytes)) mem[base + ADDR_W'(i)] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_rdata[s] <= '0;
        pipe_err[s]   <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_rdata[0] <= (accept && !req_wr) ? rd_word : '0;
      pipe_err[0]   <= accept && err;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_rdata[s] <= pipe_rdata[s-1];
        pipe_err[s]   <= pipe_err[s-1];
      end
    end
  end

  assign rsp_valid = pipe_valid[LATENCY-1] && !reset;
  assign rsp_rdata = reset ? '0 : pipe_rdata[LATENCY-1];
  assign rsp_err   = pipe_err[LATENCY-1] && !reset;

endmodule

// File: tb/tb_dmem_pipe.sv
// Bench for dmem_pipe: a default instance (cleared, latency 2) and a non-clearing
// latency-1 instance, both checked against a byte-array reference model.
module tb_dmem_pipe;

  localparam int DEPTH = 1024;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic        a_reset, a_req_valid, a_req_ready, a_req_wr, a_rsp_valid, a_rsp_err, a_busy;
  logic [63:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [1:0]  a_req_size;
  logic        b_reset, b_req_valid, b_req_ready, b_req_wr, b_rsp_valid, b_rsp_err, b_busy;
  logic [63:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [1:0]  b_req_size;

  // Expected response: [127:96] cycle it must appear in, [64] err, [63:0] rdata.
  logic [127:0] exp_a[$];
  logic [127:0] exp_b[$];
  logic [7:0]   model_a [DEPTH];
  logic [7:0]   model_b [DEPTH];

  dmem_pipe u_dut_a (
    .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_wr(a_req_wr), .req_addr(a_req_addr), .req_size(a_req_size), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy)
  );

  dmem_pipe #(.LATENCY(LAT_B), .CLEAR_ON_RESET(0)) u_dut_b (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_wr(b_req_wr), .req_addr(b_req_addr), .req_size(b_req_size), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int sel, input logic wr, input logic [63:0] addr,
                       input logic [1:0] size, input logic [63:0] wdata);
    int          waited;
    int          nb;
    int          acc;
    logic        err;
    logic [63:0] rd;
    waited = 0;
    @(negedge clk);
    while (!((sel == 0) ? a_req_ready : b_req_ready)) begin
      if (waited > 2000) begin
        chk("ready_timeout", 64'd0, 64'd1);
        return;
      end
      waited++;
      @(negedge clk);
    end
    if (sel == 0) begin
      a_req_valid = 1'b1; a_req_wr = wr; a_req_addr = addr; a_req_size = size; a_req_wdata = wdata;
    end else begin
      b_req_valid = 1'b1; b_req_wr = wr; b_req_addr = addr; b_req_size = size; b_req_wdata = wdata;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    // Reference: an access is legal when all its bytes lie inside the array.
    nb  = 1 << size;
    err = (nb > 8) || (addr > 64'(DEPTH - nb));
    rd  = '0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        if (wr) begin
          if (sel == 0) model_a[int'(addr[9:0]) + i] = wdata[8*i +: 8];
          else          model_b[int'(addr[9:0]) + i] = wdata[8*i +: 8];
        end else begin
          rd[8*i +: 8] = (sel == 0) ? model_a[int'(addr[9:0]) + i] : model_b[int'(addr[9:0]) + i];
        end
      end
    end
    if (sel == 0) exp_a.push_back({32'(acc + LAT_A - 1), 31'd0, err, rd});
    else          exp_b.push_back({32'(acc + LAT_B - 1), 31'd0, err, rd});
  endtask

  task automatic clear_model_a();
    for (int i = 0; i < DEPTH; i++) model_a[i] = 8'h00;
  endtask

  // Waits out the init sweep of instance A, measuring its length.
  task automatic check_init_a();
    int busy_cycles;
    int ready_bad;
    busy_cycles = 0;
    ready_bad   = 0;
    @(negedge clk);
    while (a_busy && busy_cycles < 5000) begin
      if (a_req_ready) ready_bad++;
      busy_cycles++;
      @(negedge clk);
    end
    chk("init_busy_cycles", 64'(busy_cycles), 64'd128);
    chk("init_ready_low", 64'(ready_bad), 64'd0);
    chk("post_init_ready", 64'(a_req_ready), 64'd1);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    logic [127:0] e;
    if (a_rsp_valid) begin
      if (exp_a.size() == 0) chk("a_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = exp_a.pop_front();
        chk("a_rsp_rdata", a_rsp_rdata, e[63:0]);
        chk("a_rsp_err", 64'(a_rsp_err), 64'(e[64]));
        chk("a_rsp_cycle", 64'(cyc), 64'(e[127:96]));
      end
    end else if (a_rsp_rdata !== '0 || a_rsp_err !== 1'b0) begin
      chk("a_idle_outputs_zero", {a_rsp_err, a_rsp_rdata[62:0]}, 64'd0);
    end
  end

  always @(negedge clk) begin
    logic [127:0] e;
    if (b_rsp_valid) begin
      if (exp_b.size() == 0) chk("b_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = exp_b.pop_front();
        chk("b_rsp_rdata", b_rsp_rdata, e[63:0]);
        chk("b_rsp_err", 64'(b_rsp_err), 64'(e[64]));
        chk("b_rsp_cycle", 64'(cyc), 64'(e[127:96]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] addr;
    logic [63:0] val;
    int          r;
    a_reset = 1'b1; b_reset = 1'b1;
    a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = '0; a_req_size = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_size = '0; b_req_wdata = '0;
    clear_model_a();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a_ready", 64'(a_req_ready), 64'd0);
    chk("reset_a_busy", 64'(a_busy), 64'd1);
    chk("reset_a_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("reset_b_busy", 64'(b_busy), 64'd0);
    chk("reset_b_ready", 64'(b_req_ready), 64'd0);
    @(posedge clk);
    #1 a_reset = 1'b0;
    check_init_a();

    // Cleared memory, sub-word reads, read-after-write, boundaries.
    issue(0, 1'b0, 64'd0,    2'd3, 64'd0);
    issue(0, 1'b0, 64'd512,  2'd3, 64'd0);
    issue(0, 1'b0, 64'd1016, 2'd3, 64'd0);
    issue(0, 1'b1, 64'd200,  2'd3, 64'h1122334455667788);
    issue(0, 1'b0, 64'd203,  2'd0, 64'd0);
    issue(0, 1'b0, 64'd206,  2'd1, 64'd0);
    issue(0, 1'b0, 64'd201,  2'd2, 64'd0);
    issue(0, 1'b1, 64'd64,   2'd2, 64'hDEADBEEF);
    issue(0, 1'b0, 64'd64,   2'd2, 64'd0);
    issue(0, 1'b1, 64'd1022, 2'd1, 64'hABCD);
    issue(0, 1'b0, 64'd1022, 2'd1, 64'd0);
    issue(0, 1'b1, 64'd1020, 2'd3, 64'h0102030405060708);
    issue(0, 1'b0, 64'd1020, 2'd2, 64'd0);
    issue(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 64'd0);
    issue(0, 1'b0, 64'd1017, 2'd3, 64'd0);
    idle(LAT_A + 2);

    // Reset with two reads in flight: neither may ever respond.
    issue(0, 1'b1, 64'd300, 2'd3, 64'hCAFEF00D12345678);
    idle(LAT_A + 2);
    issue(0, 1'b0, 64'd300, 2'd3, 64'd0);
    issue(0, 1'b0, 64'd200, 2'd3, 64'd0);
    a_reset = 1'b1;
    exp_a.delete();
    @(posedge clk);
    #1 a_reset = 1'b0;
    clear_model_a();
    check_init_a();
    issue(0, 1'b0, 64'd300, 2'd3, 64'd0);
    issue(0, 1'b0, 64'd200, 2'd3, 64'd0);

    // Randomised traffic with occasional bubbles.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       addr = 64'($urandom_range(0, DEPTH - 1));
      else if (r == 8) addr = 64'($urandom_range(DEPTH - 8, DEPTH + 3));
      else             addr = {$urandom, $urandom};
      val = {$urandom, $urandom};
      issue(0, 1'($urandom_range(0, 1)), addr, 2'($urandom_range(0, 3)), val);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(LAT_A + 3);

    // Non-clearing instance: contents survive reset, latency 1.
    b_reset = 1'b0;
    @(negedge clk);
    chk("b_ready_after_reset", 64'(b_req_ready), 64'd1);
    chk("b_busy_after_reset", 64'(b_busy), 64'd0);
    issue(1, 1'b1, 64'd8, 2'd3, 64'h8877665544332211);
    idle(2);
    b_reset = 1'b1;
    @(negedge clk);
    chk("b_ready_in_reset", 64'(b_req_ready), 64'd0);
    chk("b_busy_in_reset", 64'(b_busy), 64'd0);
    @(posedge clk);
    #1 b_reset = 1'b0;
    @(negedge clk);
    chk("b_ready_first_cycle", 64'(b_req_ready), 64'd1);
    chk("b_busy_first_cycle", 64'(b_busy), 64'd0);
    issue(1, 1'b0, 64'd8, 2'd3, 64'd0);
    for (int n = 0; n < 20; n++) begin
      addr = 64'($urandom_range(2, 120) * 8);
      issue(1, 1'b1, addr, 2'd3, {$urandom, $urandom});
      issue(1, 1'b0, addr + 64'($urandom_range(0, 4)), 2'($urandom_range(0, 2)), 64'd0);
    end
    idle(LAT_B + 3);

    chk("a_queue_drained", 64'(exp_a.size()), 64'd0);
    chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
